// File: rtl/fft_power_reader_if.sv
// AXI-Stream bundle carrying per-entry power beats (re^2 + im^2) with mic index and frame-end flag.
interface fft_power_reader_if #(
   parameter int TDATA_W = 48,
   parameter int TUSER_W = 3
) ();
   logic [TDATA_W-1:0] tdata;
   logic [TUSER_W-1:0] tuser;
   logic               tvalid;
   logic               tready;
   logic               tlast;

   modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft_power_reader.sv
// Sweeps one FFT frame out of the spectrum BRAM, squares each complex entry and streams
// the powers in address order through a credit-guarded show-ahead FIFO.
module fft_power_reader #(
   parameter int NUM_BINS   = 256,
   parameter int NUM_MICS   = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [12:0]        bram_addr,
   output logic               bram_en,
   input  logic [31:0]        bram_dout_re,
   input  logic [31:0]        bram_dout_im,
   fft_power_reader_if.master m_axis,
   output logic               busy,
   output logic               done
);
   localparam int NUM_ENTRIES = NUM_BINS * NUM_MICS;
   localparam int IDX_W       = $clog2(NUM_ENTRIES);
   localparam int USER_W      = $clog2(NUM_MICS);
   localparam int DATA_W      = 24;
   localparam int PROD_W      = 2 * DATA_W;
   localparam int PTR_W       = $clog2(FIFO_DEPTH);
   localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef logic [CNT_W:0] occ_t;

   function automatic logic signed [PROD_W-1:0] square(input logic [DATA_W-1:0] word);
      logic signed [PROD_W-1:0] s;
      s = {{DATA_W{word[DATA_W-1]}}, word};
      return s * s;
   endfunction

   // Both squares are non-negative and at most 2^46, so the unsigned sum cannot wrap.
   function automatic logic [PROD_W-1:0] power_sum(input logic signed [PROD_W-1:0] a,
                                                   input logic signed [PROD_W-1:0] b);
      return $unsigned(a) + $unsigned(b);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   state_t                   state_q;
   logic [IDX_W-1:0]         idx_q;
   logic                     vld_p0_q, vld_p1_q, vld_p2_q;
   logic [USER_W-1:0]        user_p0_q, user_p1_q, user_p2_q;
   logic                     last_p0_q, last_p1_q, last_p2_q;
   logic signed [PROD_W-1:0] re_sq_p1_q, im_sq_p1_q;
   logic [PROD_W-1:0]        pwr_p2_q;
   logic [PROD_W-1:0]        mem_data_q [FIFO_DEPTH];
   logic [USER_W-1:0]        mem_user_q [FIFO_DEPTH];
   logic                     mem_last_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]         fifo_cnt_q, fifo_cnt_d;
   occ_t                     occupancy;
   logic                     issue, fifo_push, fifo_pop, fifo_valid, head_last;
   logic                     unused_hi;

   assign unused_hi = ^{bram_dout_re[31:DATA_W], bram_dout_im[31:DATA_W]};

   // Credits cover every read already in the pipeline, so the FIFO can always absorb them.
   assign occupancy  = occ_t'(vld_p0_q) + occ_t'(vld_p1_q) + occ_t'(vld_p2_q) + occ_t'(fifo_cnt_q);
   assign issue      = (state_q == RUN) && (occupancy < occ_t'(FIFO_DEPTH));
   assign fifo_valid = (fifo_cnt_q != '0);
   assign fifo_push  = vld_p2_q;
   assign fifo_pop   = fifo_valid && m_axis.tready;
   assign head_last  = mem_last_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q <= RUN;
               idx_q   <= '0;
            end
            RUN: if (issue) begin
               if (idx_q == LAST_IDX) state_q <= DRAIN;
               else                   idx_q   <= idx_q + 1'b1;
            end
            DRAIN:   if (fifo_pop && head_last) state_q <= DONE;
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0_q <= 1'b0;
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p0_q <= issue;
         vld_p1_q <= vld_p0_q;
         vld_p2_q <= vld_p1_q;
      end
   end

   always_ff @(posedge clk) begin
      // p0: BRAM word lands next cycle; sideband captured from the issued index
      user_p0_q  <= idx_q[USER_W-1:0];
      last_p0_q  <= (idx_q == LAST_IDX);
      // p1: squares of the sign-extended 24-bit halves
      re_sq_p1_q <= square(bram_dout_re[DATA_W-1:0]);
      im_sq_p1_q <= square(bram_dout_im[DATA_W-1:0]);
      user_p1_q  <= user_p0_q;
      last_p1_q  <= last_p0_q;
      // p2: power sum, pushed into the FIFO on the following edge
      pwr_p2_q   <= power_sum(re_sq_p1_q, im_sq_p1_q);
      user_p2_q  <= user_p1_q;
      last_p2_q  <= last_p1_q;
      if (fifo_push) begin
         mem_data_q[wr_ptr_q] <= pwr_p2_q;
         mem_user_q[wr_ptr_q] <= user_p2_q;
         mem_last_q[wr_ptr_q] <= last_p2_q;
      end
   end

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (fifo_push && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
      else if (!fifo_push && fifo_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (fifo_push) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (fifo_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   // Payload is forced to zero while empty so outputs read as idle after reset.
   assign m_axis.tvalid = fifo_valid;
   assign m_axis.tdata  = fifo_valid ? mem_data_q[rd_ptr_q] : '0;
   assign m_axis.tuser  = fifo_valid ? mem_user_q[rd_ptr_q] : '0;
   assign m_axis.tlast  = fifo_valid && head_last;

   assign bram_en   = issue;
   assign bram_addr = 13'({idx_q, 2'b00});
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
endmodule

// File: tb/tb_fft_power_reader.sv
// Directed bench for fft_power_reader: ramp, extreme-value, backpressure, hold-off and reset frames.
module tb_fft_power_reader;
   localparam int N     = 2048;
   localparam int DEPTH = 8;

   typedef struct {
      int          idx;
      logic [31:0] re;
      logic [31:0] im;
      logic [47:0] exp_data;
      logic [2:0]  exp_user;
      logic        exp_last;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [12:0] bram_addr;
   logic        bram_en;
   logic [31:0] bram_dout_re, bram_dout_im;
   logic        busy, done;

   fft_power_reader_if axis ();

   fft_power_reader #(.NUM_BINS(256), .NUM_MICS(8), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .bram_addr(bram_addr), .bram_en(bram_en),
      .bram_dout_re(bram_dout_re), .bram_dout_im(bram_dout_im),
      .m_axis(axis), .busy(busy), .done(done));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM port B model, one-cycle read latency
   logic [31:0] mem_re [N];
   logic [31:0] mem_im [N];
   always @(posedge clk)
      if (bram_en) begin
         bram_dout_re <= mem_re[bram_addr[12:2]];
         bram_dout_im <= mem_im[bram_addr[12:2]];
      end

   // Monitor state (written only by the monitor process)
   int beat_total = 0, issued_total = 0, done_total = 0, stall_viol = 0, addr_err = 0;
   int outst = 0, max_outst = 0, en_rise_cyc = 0, valid_rise_cyc = 0, done_cyc = 0, mon_idx;
   logic [47:0] got_data [N];
   logic [2:0]  got_user [N];
   logic        got_last [N];
   int          got_cyc  [N];
   logic        prev_en = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0;
   logic [47:0] held_data;
   logic [2:0]  held_user;
   logic        held_last;

   // Frame bookkeeping (written only by the main process)
   int frame_base = 0, issue_base = 0, done_base = 0, e0 = 0, tready_mode = 0;
   int n_pass = 0, n_total = 0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         outst = 0; prev_en = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0;
      end else begin
         if (bram_en) begin
            if (bram_addr !== 13'((issued_total - issue_base) * 4)) addr_err++;
            if (!prev_en) en_rise_cyc = cyc;
            issued_total++;
            outst++;
         end
         if (axis.tvalid && !prev_valid) valid_rise_cyc = cyc;
         if (prev_stall && (!axis.tvalid || axis.tdata !== held_data ||
                            axis.tuser !== held_user || axis.tlast !== held_last)) stall_viol++;
         if (axis.tvalid && axis.tready) begin
            mon_idx = beat_total - frame_base;
            if (mon_idx >= 0 && mon_idx < N) begin
               got_data[mon_idx] = axis.tdata;
               got_user[mon_idx] = axis.tuser;
               got_last[mon_idx] = axis.tlast;
               got_cyc[mon_idx]  = cyc;
            end
            beat_total++;
            outst--;
         end
         if (outst > max_outst) max_outst = outst;
         if (done) begin done_total++; done_cyc = cyc; end
         prev_en    = bram_en;
         prev_valid = axis.tvalid;
         prev_stall = axis.tvalid && !axis.tready;
         held_data  = axis.tdata;
         held_user  = axis.tuser;
         held_last  = axis.tlast;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [47:0] ramp_pwr(input int i);
      int re, im;
      re = i % 8 + 1;
      im = i / 8;
      return 48'(re * re + im * im);
   endfunction

   task automatic fill_ramp();
      for (int i = 0; i < N; i++) begin
         mem_re[i] = 32'(i % 8 + 1);
         mem_im[i] = 32'(i / 8);
      end
   endtask

   task automatic drive_tready();
      case (tready_mode)
         0:       axis.tready = 1'b1;
         1:       axis.tready = ($urandom_range(0, 99) < 30);
         default: axis.tready = 1'b0;
      endcase
   endtask

   task automatic start_frame();
      frame_base = beat_total;
      issue_base = issued_total;
      done_base  = done_total;
      @(posedge clk); #1 start = 1'b1; drive_tready();
      @(posedge clk); #1 start = 1'b0; e0 = cyc; drive_tready();
   endtask

   task automatic run_until_done(input string name, input int budget, input int pulse_at);
      int k = 0;
      while (done_total == done_base && k < budget) begin
         @(posedge clk); #1;
         drive_tready();
         start = (k == pulse_at);
         k++;
      end
      start = 1'b0;
      check({name, "_done_pulses"}, 64'(done_total - done_base), 64'(1));
   endtask

   task automatic compare_ramp(input string name);
      int bad = 0;
      check({name, "_beats"}, 64'(beat_total - frame_base), 64'(N));
      for (int i = 0; i < N; i++)
         if (got_data[i] !== ramp_pwr(i) || got_user[i] !== 3'(i % 8) || got_last[i] !== (i == N - 1)) begin
            if (bad == 0)
               $display("%s: first differing beat %0d tdata 0x%0h tuser %0d tlast %0b", name, i,
                        got_data[i], got_user[i], got_last[i]);
            bad++;
         end
      check({name, "_bad_beats"}, 64'(bad), 64'(0));
   endtask

   vec_t ramp_vec [4];
   vec_t ext_vec  [6];

   initial begin
      ramp_vec[0] = '{0,    32'h0, 32'h0, 48'd1,     3'd0, 1'b0};
      ramp_vec[1] = '{9,    32'h0, 32'h0, 48'd5,     3'd1, 1'b0};
      ramp_vec[2] = '{26,   32'h0, 32'h0, 48'd18,    3'd2, 1'b0};
      ramp_vec[3] = '{2047, 32'h0, 32'h0, 48'd65089, 3'd7, 1'b1};
      ext_vec[0]  = '{0,    32'hFF80_0000, 32'hFF80_0000, 48'h8000_0000_0000, 3'd0, 1'b0};
      ext_vec[1]  = '{1,    32'h007F_FFFF, 32'h0000_0000, 48'h3FFF_FF00_0001, 3'd1, 1'b0};
      ext_vec[2]  = '{2,    32'hAB00_0003, 32'h00FF_FFFC, 48'd25,             3'd2, 1'b0};
      ext_vec[3]  = '{5,    32'h0000_0000, 32'h0000_0000, 48'd0,              3'd5, 1'b0};
      ext_vec[4]  = '{13,   32'hFFFF_FFFE, 32'h7F00_0005, 48'd29,             3'd5, 1'b0};
      ext_vec[5]  = '{2047, 32'hFFFF_FFFF, 32'h0000_0002, 48'd5,              3'd7, 1'b1};

      axis.tready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 64'({bram_addr, bram_en, axis.tvalid, axis.tuser, axis.tlast, busy, done}), 64'(0));
      check("reset_tdata", 64'(axis.tdata), 64'(0));
      rst_n = 1'b1;

      // Ramp frame, tready high, start re-pulsed while busy
      fill_ramp();
      tready_mode = 0;
      start_frame();
      run_until_done("ramp", 5000, 100);
      compare_ramp("ramp");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ramp%0d_tdata", i), 64'(got_data[ramp_vec[i].idx]), 64'(ramp_vec[i].exp_data));
         check($sformatf("ramp%0d_tuser", i), 64'(got_user[ramp_vec[i].idx]), 64'(ramp_vec[i].exp_user));
         check($sformatf("ramp%0d_tlast", i), 64'(got_last[ramp_vec[i].idx]), 64'(ramp_vec[i].exp_last));
      end
      check("first_bram_en_latency", 64'(en_rise_cyc - e0), 64'(0));
      check("first_tvalid_latency", 64'(valid_rise_cyc - e0), 64'(4));
      check("first_beat_latency", 64'(got_cyc[0] - e0), 64'(4));
      check("beats_contiguous", 64'(got_cyc[N-1] - got_cyc[0]), 64'(N - 1));
      check("done_after_tlast", 64'(done_cyc - got_cyc[N-1]), 64'(1));
      repeat (20) begin @(posedge clk); #1; end
      check("repulse_ignored_beats", 64'(beat_total - frame_base), 64'(N));
      check("repulse_ignored_done", 64'(done_total - done_base), 64'(1));
      check("idle_busy", 64'(busy), 64'(0));

      // Second identical frame after done
      start_frame();
      check("busy_after_start", 64'(busy), 64'(1));
      run_until_done("ramp2", 5000, -1);
      compare_ramp("ramp2");

      // Extreme operand values
      for (int i = 0; i < N; i++) begin mem_re[i] = '0; mem_im[i] = '0; end
      for (int i = 0; i < 6; i++) begin
         mem_re[ext_vec[i].idx] = ext_vec[i].re;
         mem_im[ext_vec[i].idx] = ext_vec[i].im;
      end
      start_frame();
      run_until_done("ext", 5000, -1);
      check("ext_beats", 64'(beat_total - frame_base), 64'(N));
      for (int i = 0; i < 6; i++) begin
         check($sformatf("ext%0d_tdata", i), 64'(got_data[ext_vec[i].idx]), 64'(ext_vec[i].exp_data));
         check($sformatf("ext%0d_tuser", i), 64'(got_user[ext_vec[i].idx]), 64'(ext_vec[i].exp_user));
         check($sformatf("ext%0d_tlast", i), 64'(got_last[ext_vec[i].idx]), 64'(ext_vec[i].exp_last));
      end

      // Random backpressure, 30% ready duty
      fill_ramp();
      tready_mode = 1;
      start_frame();
      run_until_done("bp", 20000, -1);
      compare_ramp("bp");

      // tready held low: credit limit caps the reads at the FIFO depth
      tready_mode = 2;
      start_frame();
      repeat (100) begin @(posedge clk); #1; end
      check("hold_reads_issued", 64'(issued_total - issue_base), 64'(DEPTH));
      check("hold_bram_en", 64'(bram_en), 64'(0));
      check("hold_tvalid", 64'(axis.tvalid), 64'(1));
      check("hold_tdata_head", 64'(axis.tdata), 64'(ramp_pwr(0)));
      check("hold_beats", 64'(beat_total - frame_base), 64'(0));
      tready_mode = 0;
      run_until_done("hold", 5000, -1);
      compare_ramp("hold");
      check("stall_stability_errors", 64'(stall_viol), 64'(0));
      check("max_outstanding", 64'(max_outst), 64'(DEPTH));

      // Asynchronous reset in the middle of a frame
      start_frame();
      for (int k = 0; k < 3000 && (beat_total - frame_base) < 500; k++) begin @(posedge clk); #1; end
      check("mid_reset_reached_500", 64'(beat_total - frame_base >= 500), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mid_reset_ctrl", 64'({bram_addr, bram_en, axis.tvalid, axis.tuser, axis.tlast, busy, done}), 64'(0));
      check("mid_reset_tdata", 64'(axis.tdata), 64'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      start_frame();
      run_until_done("post_reset", 5000, -1);
      compare_ramp("post_reset");
      check("addr_sequence_errors", 64'(addr_err), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
